spike_scheduler: RTL and testbench

- Responder side of the token-controller ↔ scheduler interface inside one neurosynaptic core.
- Buffers incoming axon spikes from the router into per-tick rows, keyed by delivery-tick offset.
- Presents the current tick's row as axon_spikes.
- On scheduler_set, freezes the current row for processing. On scheduler_clr, zeroes that row and advances to the next tick.

---
 rtl/scheduler_pkg.sv | 11 +
 rtl/spike_scheduler_if.sv | 32 +++
 rtl/spike_row_bank.sv | 29 ++
 rtl/spike_scheduler.sv | 82 ++++++++
 tb/tb_spike_scheduler.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/scheduler_pkg.sv
// Shared types and default widths for the spike scheduler slice.
package scheduler_pkg;
  localparam int AXON_W = $clog2(256);
  localparam int TICK_W = $clog2(16);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    CLEAR = 2'd2
  } state_t;
endpackage

// File: rtl/spike_scheduler_if.sv
// Token-controller / router facing bundle of the spike scheduler.
interface spike_scheduler_if #(
  parameter int NUM_AXONS = 2 ** scheduler_pkg::AXON_W,
  parameter int NUM_TICKS = 2 ** scheduler_pkg::TICK_W
);
  localparam int AW = $clog2(NUM_AXONS);
  localparam int TW = $clog2(NUM_TICKS);

  // Packet handshake: a packet transfers on any posedge where packet_valid and
  // packet_ready are both 1; the master holds axon/tick stable while valid is
  // high and not yet accepted; ready never depends on valid.
  logic                 scheduler_set;
  logic                 scheduler_clr;
  logic                 packet_valid;
  logic [AW-1:0]        packet_axon;
  logic [TW-1:0]        packet_tick;
  logic                 packet_ready;
  logic [NUM_AXONS-1:0] axon_spikes;
  logic [TW-1:0]        current_tick;
  logic                 error;
  scheduler_pkg::state_t state;

  modport master (
    output scheduler_set, scheduler_clr, packet_valid, packet_axon, packet_tick,
    input  packet_ready, axon_spikes, current_tick, error, state
  );

  modport slave (
    input  scheduler_set, scheduler_clr, packet_valid, packet_axon, packet_tick,
    output packet_ready, axon_spikes, current_tick, error, state
  );
endinterface

// File: rtl/spike_row_bank.sv
// Flop-based tick-row storage: one OR-write bit port, one row clear, one comb read.
module spike_row_bank #(
  parameter int NUM_AXONS = 256,
  parameter int NUM_TICKS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_TICKS)-1:0] wr_row,
  input  logic [$clog2(NUM_AXONS)-1:0] wr_axon,
  input  logic                         clr_en,
  input  logic [$clog2(NUM_TICKS)-1:0] clr_row,
  input  logic [$clog2(NUM_TICKS)-1:0] rd_row,
  output logic [NUM_AXONS-1:0]         rd_data
);
  logic [NUM_AXONS-1:0] rows [NUM_TICKS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_TICKS; i++) rows[i] <= '0;
    end else begin
      if (clr_en) rows[clr_row] <= '0;
      // The controller never writes and clears in the same cycle.
      if (wr_en) rows[wr_row][wr_axon] <= 1'b1;
    end
  end

  assign rd_data = rows[rd_row];
endmodule

// File: rtl/spike_scheduler.sv
// Tick scheduler: buffers router spikes per delivery tick and hands the current
// row to the token controller across a set/clr processing window.
module spike_scheduler
  import scheduler_pkg::*;
#(
  parameter int NUM_AXONS = 2 ** AXON_W,
  parameter int NUM_TICKS = 2 ** TICK_W
) (
  input  logic             clk,
  input  logic             rst,
  spike_scheduler_if.slave bus
);
  localparam int TW = $clog2(NUM_TICKS);

  state_t               state_q, state_d;
  logic [TW-1:0]        read_ptr;
  logic [TW-1:0]        wr_row;
  logic                 error_q;
  logic                 err_set;
  logic                 accept;
  logic                 wr_en;
  logic [NUM_AXONS-1:0] row_data;

  assign bus.packet_ready = rst && (state_q != CLEAR);
  assign accept           = bus.packet_valid && bus.packet_ready;
  assign wr_en            = accept && (bus.packet_tick != '0);
  // Target slot uses the pre-advance pointer, even alongside scheduler_clr.
  assign wr_row           = read_ptr + bus.packet_tick;

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.scheduler_set) state_d = BUSY;
        if (bus.scheduler_clr) err_set = 1'b1;
      end
      BUSY: begin
        if (bus.scheduler_clr) state_d = CLEAR;
        if (bus.scheduler_set) err_set = 1'b1;
      end
      CLEAR: begin
        state_d = IDLE;
        if (bus.scheduler_set || bus.scheduler_clr) err_set = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (accept && (bus.packet_tick == '0)) err_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      read_ptr <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) read_ptr <= read_ptr + 1'b1;
      if (err_set) error_q <= 1'b1;
    end
  end

  spike_row_bank #(
    .NUM_AXONS(NUM_AXONS),
    .NUM_TICKS(NUM_TICKS)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_row (wr_row),
    .wr_axon(bus.packet_axon),
    .clr_en (state_q == CLEAR),
    .clr_row(read_ptr),
    .rd_row (read_ptr),
    .rd_data(row_data)
  );

  assign bus.axon_spikes  = row_data;
  assign bus.current_tick = read_ptr;
  assign bus.error        = error_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_spike_scheduler.sv
// Scoreboarded bench for spike_scheduler against a queue/array tick model.
module tb_spike_scheduler;
  localparam int NA = 256;
  localparam int NT = 16;
  localparam int W  = NA + 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  spike_scheduler_if #(.NUM_AXONS(NA), .NUM_TICKS(NT)) bus ();

  spike_scheduler #(.NUM_AXONS(NA), .NUM_TICKS(NT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: one bit vector per tick slot plus pointer and error flag.
  logic [NA-1:0] m_rows [NT];
  int            m_ptr;
  bit            m_err;

  logic [W-1:0] exp_q [$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_rows[i] = '0;
    m_ptr = 0;
    m_err = 0;
  endtask

  task automatic model_write(input int axon, input int tick);
    if (tick == 0) m_err = 1;
    else m_rows[(m_ptr + tick) % NT][axon] = 1'b1;
  endtask

  task automatic model_advance();
    m_rows[m_ptr] = '0;
    m_ptr = (m_ptr + 1) % NT;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int axon, input int tick);
    bit done;
    done = 0;
    bus.packet_valid = 1'b1;
    bus.packet_axon  = 8'(axon);
    bus.packet_tick  = 4'(tick);
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      done = bus.packet_ready;
      step();
    end
    bus.packet_valid = 1'b0;
    check("pkt_accept", W'(done), W'(1));
    if (done) model_write(axon, tick);
  endtask

  task automatic tick_set();
    exp_q.push_back({4'(m_ptr), m_rows[m_ptr]});
    bus.scheduler_set = 1'b1;
    step();
    bus.scheduler_set = 1'b0;
  endtask

  task automatic tick_clr();
    bus.scheduler_clr = 1'b1;
    step();
    bus.scheduler_clr = 1'b0;
    step();
    model_advance();
  endtask

  task automatic tick_cycle();
    tick_set();
    tick_clr();
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check({tag, "_error"}, W'(bus.error), W'(m_err));
    check({tag, "_tick"}, W'(bus.current_tick), W'(m_ptr));
    check({tag, "_ready"}, W'(bus.packet_ready), W'(1));
    step();
  endtask

  // Monitor: the row and pointer presented on every sampled scheduler_set.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus.scheduler_set === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_set: got set with no expected row");
      end else begin
        e = exp_q.pop_front();
        check("row_at_set", W'(bus.axon_spikes), W'(e[NA-1:0]));
        check("tick_at_set", W'(bus.current_tick), W'(e[W-1:NA]));
      end
    end
  end

  initial begin
    bus.scheduler_set = 1'b0;
    bus.scheduler_clr = 1'b0;
    bus.packet_valid  = 1'b0;
    bus.packet_axon   = '0;
    bus.packet_tick   = '0;
    model_reset();

    repeat (3) step();
    @(negedge clk);
    check("ready_in_reset", W'(bus.packet_ready), W'(0));
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("reset_spikes", W'(bus.axon_spikes), W'(0));
    check("reset_tick", W'(bus.current_tick), W'(0));
    check("reset_ready", W'(bus.packet_ready), W'(1));
    check("reset_error", W'(bus.error), W'(0));
    step();

    // Single spike one tick ahead.
    send_pkt(5, 1);
    tick_cycle();
    tick_cycle();
    check_status("after_two_ticks");

    // Duplicates are idempotent; two axons in the same future slot.
    send_pkt(7, 3);
    send_pkt(7, 3);
    send_pkt(200, 3);
    repeat (3) tick_cycle();
    tick_cycle();
    check_status("dup");

    // Pointer wrap: write from slot 14 with offset 2 lands in slot 0.
    while (m_ptr != 14) tick_cycle();
    send_pkt(0, 2);
    repeat (2) tick_cycle();
    tick_cycle();
    check_status("wrap");

    // Packet held across the CLEAR cycle is accepted against the new pointer.
    tick_set();
    bus.scheduler_clr = 1'b1;
    step();
    bus.scheduler_clr = 1'b0;
    bus.packet_valid  = 1'b1;
    bus.packet_axon   = 8'd42;
    bus.packet_tick   = 4'd1;
    @(negedge clk);
    check("ready_in_clear", W'(bus.packet_ready), W'(0));
    step();
    model_advance();
    @(negedge clk);
    check("ready_after_clear", W'(bus.packet_ready), W'(1));
    step();
    bus.packet_valid = 1'b0;
    model_write(42, 1);
    repeat (3) tick_cycle();

    // Write coinciding with scheduler_clr uses the pre-advance pointer.
    tick_set();
    bus.scheduler_clr = 1'b1;
    bus.packet_valid  = 1'b1;
    bus.packet_axon   = 8'd9;
    bus.packet_tick   = 4'd4;
    step();
    bus.scheduler_clr = 1'b0;
    bus.packet_valid  = 1'b0;
    model_write(9, 4);
    step();
    model_advance();
    repeat (4) tick_cycle();
    check_status("clr_write");

    // Randomised traffic in IDLE and BUSY.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) send_pkt($urandom_range(0, NA - 1), $urandom_range(1, NT - 1));
      tick_set();
      repeat ($urandom_range(0, 2)) send_pkt($urandom_range(0, NA - 1), $urandom_range(1, NT - 1));
      tick_clr();
      check_status("rand");
    end

    // Illegal zero offset: dropped, flags error.
    send_pkt(77, 0);
    check_status("zero_offset");
    tick_cycle();

    // scheduler_clr while IDLE: error, no pointer move.
    bus.scheduler_clr = 1'b1;
    step();
    bus.scheduler_clr = 1'b0;
    step();
    check_status("clr_idle");

    // Reset clears error and storage.
    rst = 1'b0;
    step();
    rst = 1'b1;
    model_reset();
    check_status("reset_again");

    // Reset mid-BUSY loses in-flight spikes.
    send_pkt(3, 1);
    tick_set();
    rst = 1'b0;
    step();
    rst = 1'b1;
    model_reset();
    tick_cycle();
    tick_cycle();
    check_status("reset_busy");

    repeat (3) step();
    check("exp_q_drained", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
